// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit counter table + BTB with combinational lookup, misprediction detection and statistics.
module branch_predictor #(
  parameter int         IDX_BITS  = 6,
  parameter logic [1:0] RESET_CNT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        misprediction,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);
  localparam int N  = 1 << IDX_BITS;
  localparam int TW = 30 - IDX_BITS;
  logic [1:0]          cnt_q    [N];
  logic [N-1:0]        valid_q;
  logic [TW-1:0]       tag_q    [N];
  logic [31:0]         target_q [N];
  logic [31:0]         branch_count_q, mispredict_count_q;
  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TW-1:0]       if_tag, ex_tag;
  logic                hit;
  logic [1:0]          cnt_d;
  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[31:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[31:IDX_BITS+2];
  always_comb begin
    hit           = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken    = hit && cnt_q[if_idx][1];
    pred_target   = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
    misprediction = ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target));
    redirect_pc   = ex_taken ? ex_target : ex_pc + 32'd4;
    cnt_d         = ex_taken ? ((cnt_q[ex_idx] == 2'b11) ? 2'b11 : cnt_q[ex_idx] + 2'd1)
                             : ((cnt_q[ex_idx] == 2'b00) ? 2'b00 : cnt_q[ex_idx] - 2'd1);
  end
  // Counter trains on every resolution even when the tag aliases; BTB fields only on taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i]    <= RESET_CNT;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
      valid_q            <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (ex_valid) begin
      cnt_q[ex_idx]  <= cnt_d;
      branch_count_q <= branch_count_q + 32'd1;
      if (misprediction) mispredict_count_q <= mispredict_count_q + 32'd1;
      if (ex_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target;
      end
    end
  end
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table plus reset sequences for branch_predictor.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        misprediction;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  int checks = 0;
  int errors = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .misprediction(misprediction), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [31:0] epc;
    logic        et;
    logic [31:0] etgt;
    logic        ept;
    logic [31:0] eptgt;
    logic [31:0] ipc;
    logic        x_pt;
    logic [31:0] x_tgt;
    logic        x_mis;
    logic [31:0] x_redir;
    logic [31:0] x_bc;
    logic [31:0] x_mc;
  } vec_t;

  vec_t v [18];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] epc, input logic et, input logic [31:0] etgt,
                       input logic ept, input logic [31:0] eptgt, input logic [31:0] ipc);
    ex_valid = ev; ex_pc = epc; ex_taken = et; ex_target = etgt;
    ex_pred_taken = ept; ex_pred_target = eptgt; if_pc = ipc;
  endtask

  initial begin
    //      ev    ex_pc       tk    ex_tgt     ptk   ptgt        if_pc         x_pt  x_tgt         mis   redir       bc     mc
    v[0]  = '{1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   32'h40,       1'b0, 32'h44,       1'b0, 32'h0,   32'd0, 32'd0};
    v[1]  = '{1'b1, 32'h40,    1'b1, 32'h100, 1'b0, 32'h0,   32'h40,       1'b0, 32'h44,       1'b1, 32'h100, 32'd0, 32'd0};
    v[2]  = '{1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   32'h40,       1'b1, 32'h100,      1'b0, 32'h0,   32'd1, 32'd1};
    v[3]  = '{1'b1, 32'h40,    1'b1, 32'h100, 1'b1, 32'h100, 32'h140,      1'b0, 32'h144,      1'b0, 32'h100, 32'd1, 32'd1};
    v[4]  = '{1'b1, 32'h40,    1'b1, 32'h100, 1'b1, 32'h100, 32'h40,       1'b1, 32'h100,      1'b0, 32'h100, 32'd2, 32'd1};
    v[5]  = '{1'b1, 32'h40,    1'b1, 32'h100, 1'b1, 32'h100, 32'h40,       1'b1, 32'h100,      1'b0, 32'h100, 32'd3, 32'd1};
    v[6]  = '{1'b1, 32'h40,    1'b0, 32'h100, 1'b1, 32'h100, 32'h40,       1'b1, 32'h100,      1'b1, 32'h44,  32'd4, 32'd1};
    v[7]  = '{1'b1, 32'h40,    1'b0, 32'h100, 1'b1, 32'h100, 32'h40,       1'b1, 32'h100,      1'b1, 32'h44,  32'd5, 32'd2};
    v[8]  = '{1'b0, 32'h40,    1'b1, 32'h100, 1'b0, 32'h0,   32'h40,       1'b0, 32'h44,       1'b0, 32'h0,   32'd6, 32'd3};
    v[9]  = '{1'b1, 32'h40,    1'b1, 32'h100, 1'b0, 32'h0,   32'h40,       1'b0, 32'h44,       1'b1, 32'h100, 32'd6, 32'd3};
    v[10] = '{1'b1, 32'h40,    1'b1, 32'h200, 1'b1, 32'h100, 32'h40,       1'b1, 32'h100,      1'b1, 32'h200, 32'd7, 32'd4};
    v[11] = '{1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   32'h40,       1'b1, 32'h200,      1'b0, 32'h0,   32'd8, 32'd5};
    v[12] = '{1'b1, 32'h140,   1'b1, 32'h300, 1'b0, 32'h0,   32'h140,      1'b0, 32'h144,      1'b1, 32'h300, 32'd8, 32'd5};
    v[13] = '{1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   32'h140,      1'b1, 32'h300,      1'b0, 32'h0,   32'd9, 32'd6};
    v[14] = '{1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   32'h40,       1'b0, 32'h44,       1'b0, 32'h0,   32'd9, 32'd6};
    v[15] = '{1'b1, 32'h8,     1'b0, 32'h0,   1'b0, 32'h0,   32'h8,        1'b0, 32'hC,        1'b0, 32'hC,   32'd9, 32'd6};
    v[16] = '{1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   32'hFFFFFFFC, 1'b0, 32'h0,        1'b0, 32'h0,   32'd10, 32'd6};
    v[17] = '{1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   32'h142,      1'b1, 32'h300,      1'b0, 32'h0,   32'd10, 32'd6};
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(v[i].ev, v[i].epc, v[i].et, v[i].etgt, v[i].ept, v[i].eptgt, v[i].ipc);
      #1;
      chk("pred_taken", i, {31'd0, pred_taken}, {31'd0, v[i].x_pt});
      chk("pred_target", i, pred_target, v[i].x_tgt);
      chk("misprediction", i, {31'd0, misprediction}, {31'd0, v[i].x_mis});
      if (v[i].ev) chk("redirect_pc", i, redirect_pc, v[i].x_redir);
      chk("branch_count", i, branch_count, v[i].x_bc);
      chk("mispredict_count", i, mispredict_count, v[i].x_mc);
      @(posedge clk);
      #1;
    end
    // Reset mid-training with a taken branch in the reset cycle: the branch must be dropped.
    rst = 1'b1;
    drive(1'b1, 32'h140, 1'b1, 32'h400, 1'b0, 32'h0, 32'h140);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 32'h140, 1'b1, 32'h400, 1'b0, 32'h0, 32'h140);
    #1;
    chk("rst_pred_taken", 100, {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_target", 100, pred_target, 32'h144);
    chk("rst_misprediction", 100, {31'd0, misprediction}, 32'd0);
    chk("rst_branch_count", 100, branch_count, 32'd0);
    chk("rst_mispredict_count", 100, mispredict_count, 32'd0);
    if_pc = 32'h40;
    #1;
    chk("rst_pred_taken_40", 101, {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_target_40", 101, pred_target, 32'h44);
    @(posedge clk);
    #1;
    // A single taken resolution from the weakly-not-taken reset value flips the prediction.
    drive(1'b1, 32'h40, 1'b1, 32'h500, 1'b0, 32'h0, 32'h40);
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h40);
    #1;
    chk("post_rst_pred_taken", 102, {31'd0, pred_taken}, 32'd1);
    chk("post_rst_pred_target", 102, pred_target, 32'h500);
    chk("post_rst_branch_count", 102, branch_count, 32'd1);
    chk("post_rst_mispredict_count", 102, mispredict_count, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
